// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample width, channel codes and the
// I2S receiver state encoding.
package audio_pkg;

   localparam int unsigned SAMPLE_WIDTH_DEFAULT = 16;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT
   } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// PCM word stream from the I2S receiver to the visualiser front end.
//   sample_out    : received sample, two's complement, MSB-first on the wire
//   channel_out   : 0 = left, 1 = right
//   valid_out     : sample_out/channel_out hold a word
//   ready_in      : consumer takes the word when valid_out & ready_in
//   overrun_out   : sticky, a completed word was dropped (output full)
//   short_err_out : sticky, a slot ended before a full word was captured
interface i2s_rx_if
   import audio_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT
);

   logic [SAMPLE_WIDTH-1:0] sample_out;
   logic                    channel_out;
   logic                    valid_out;
   logic                    ready_in;
   logic                    overrun_out;
   logic                    short_err_out;

   modport master (
      output sample_out,
      output channel_out,
      output valid_out,
      output overrun_out,
      output short_err_out,
      input  ready_in
   );

   modport slave (
      input  sample_out,
      input  channel_out,
      input  valid_out,
      input  overrun_out,
      input  short_err_out,
      output ready_in
   );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input plus a rising-edge strobe.
//   clk    : destination clock
//   rst    : synchronous, active-high reset
//   din    : asynchronous input
//   sync   : synchronised level (registered, SYNC_STAGES flops deep, min 2)
//   rise_c : one-cycle strobe, sync high and previous sync low
module sync_edge_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] stages;
   logic                   prev;

   // Synchroniser chain and one-cycle history of its output
   always_ff @(posedge clk) begin
      if (rst) begin
         stages <= '0;
         prev   <= 1'b0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], din};
         prev   <= stages[SYNC_STAGES-1];
      end
   end

   assign sync   = stages[SYNC_STAGES-1];
   assign rise_c = sync & ~prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: samples lrclk/sdata on synchronised bclk rising edges,
// deserialises one MSB-first word per slot and presents it on a valid/ready
// port, flagging dropped words (overrun) and truncated slots (short_err).
//   clk_in   : system clock, sole clock of the block
//   rst      : synchronous, active-high reset
//   bclk_in  : I2S bit clock (asynchronous, at most clk_in/4)
//   lrclk_in : word select, 0 = left, 1 = right
//   sdata_in : serial data
//   bus      : PCM word output port (i2s_rx_if master)
module i2s_rx
   import audio_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic     clk_in,
   input  logic     rst,
   input  logic     bclk_in,
   input  logic     lrclk_in,
   input  logic     sdata_in,
   i2s_rx_if.master bus
);

   localparam int unsigned     CNT_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_WIDTH - 1);

   logic bclk_sync_unused, lr_rise_unused, sd_rise_unused;
   logic bclk_rise_c, lr_s, d_s, lr_edge_c, complete_c;

   i2s_rx_state_t           state_q, state_nxt;
   logic                    ch_q, ch_nxt;
   logic [CNT_W-1:0]        count_q, count_nxt;
   logic [SAMPLE_WIDTH-2:0] shift_q, shift_nxt;
   logic                    lr_prev_q, lr_prev_nxt;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_nxt, word_c;
   logic                    channel_q, channel_nxt;
   logic                    valid_q, valid_nxt;
   logic                    overrun_q, overrun_nxt;
   logic                    short_err_q, short_err_nxt;

   // Equal-depth synchronisers keep lrclk and sdata aligned with the bclk strobe
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
      .clk(clk_in), .rst(rst), .din(bclk_in), .sync(bclk_sync_unused), .rise_c(bclk_rise_c));
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk (
      .clk(clk_in), .rst(rst), .din(lrclk_in), .sync(lr_s), .rise_c(lr_rise_unused));
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sdata (
      .clk(clk_in), .rst(rst), .din(sdata_in), .sync(d_s), .rise_c(sd_rise_unused));

   assign lr_edge_c = lr_s ^ lr_prev_q;
   assign word_c    = {shift_q, d_s};

   // State and datapath registers
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q     <= IDLE;
         ch_q        <= CH_LEFT;
         count_q     <= '0;
         shift_q     <= '0;
         lr_prev_q   <= 1'b0;
         sample_q    <= '0;
         channel_q   <= CH_LEFT;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         short_err_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         ch_q        <= ch_nxt;
         count_q     <= count_nxt;
         shift_q     <= shift_nxt;
         lr_prev_q   <= lr_prev_nxt;
         sample_q    <= sample_nxt;
         channel_q   <= channel_nxt;
         valid_q     <= valid_nxt;
         overrun_q   <= overrun_nxt;
         short_err_q <= short_err_nxt;
      end
   end

   // Slot tracking on bclk rises, then output register / handshake update
   always_comb begin
      state_nxt     = state_q;
      ch_nxt        = ch_q;
      count_nxt     = count_q;
      shift_nxt     = shift_q;
      lr_prev_nxt   = lr_prev_q;
      sample_nxt    = sample_q;
      channel_nxt   = channel_q;
      valid_nxt     = valid_q;
      overrun_nxt   = overrun_q;
      short_err_nxt = short_err_q;
      complete_c    = 1'b0;

      if (bclk_rise_c) begin
         lr_prev_nxt = lr_s;
         // The bit sampled alongside an lrclk edge belongs to the previous slot
         if (lr_edge_c) begin
            ch_nxt    = lr_s ? CH_RIGHT : CH_LEFT;
            count_nxt = '0;
            state_nxt = SHIFT;
            if (state_q == SHIFT) begin
               short_err_nxt = 1'b1;
            end
         end else if (state_q == SHIFT) begin
            shift_nxt = word_c[SAMPLE_WIDTH-2:0];
            if (count_q == LAST) begin
               complete_c = 1'b1;
               state_nxt  = WAIT;
            end else begin
               count_nxt = count_q + CNT_W'(1);
            end
         end
      end

      // A word completing during a handshake replaces the accepted one
      if (complete_c) begin
         if (!valid_q || bus.ready_in) begin
            sample_nxt  = word_c;
            channel_nxt = ch_q;
            valid_nxt   = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (valid_q && bus.ready_in) begin
         valid_nxt = 1'b0;
      end
   end

   assign bus.sample_out    = sample_q;
   assign bus.channel_out   = channel_q;
   assign bus.valid_out     = valid_q;
   assign bus.overrun_out   = overrun_q;
   assign bus.short_err_out = short_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: table-driven slot sequences, hand-written
// handshake/overrun/reset sequences and a randomized stream checked against a
// segment-based reference model.
module tb_i2s_rx;
   import audio_pkg::*;

   localparam int unsigned W    = 16;
   localparam int unsigned SYNC = 2;
   localparam int          NV   = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;

   i2s_rx_if #(.SAMPLE_WIDTH(W)) bus ();

   i2s_rx #(.SAMPLE_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
      .clk_in(clk), .rst(rst), .bclk_in(bclk), .lrclk_in(lrclk), .sdata_in(sdata), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic         ch;
      logic [W-1:0] sample;
   } word_t;

   typedef struct {
      int           grp;
      bit           lr;
      int           nbits;
      logic [31:0]  data;
      bit           emit;
      logic [W-1:0] exp_sample;
   } vec_t;

   word_t got_q[$];
   word_t exp_q[$];
   bit    lr_s[$];
   bit    d_s[$];
   vec_t  vecs[NV];
   bit    grp_short[2];
   int    n_tests = 0;
   int    n_fail  = 0;
   bit    rand_ready = 1'b0;

   // Accepted words, sampled away from the active edge
   always @(negedge clk) begin
      if (!rst && bus.valid_out && bus.ready_in)
         got_q.push_back(word_t'({bus.channel_out, bus.sample_out}));
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got stuck expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) bus.ready_in = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rand_ready   = 1'b0;
      bclk         = 1'b0;
      lrclk        = 1'b0;
      sdata        = 1'b0;
      bus.ready_in = 1'b0;
      rst          = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      got_q.delete();
      lr_s.delete();
      d_s.delete();
   endtask

   // One slot: a don't-care delay bit, then nbits data bits MSB first
   task automatic add_slot(input bit lr, input int nbits, input logic [31:0] data);
      lr_s.push_back(lr);
      d_s.push_back(1'($urandom_range(0, 1)));
      for (int i = nbits - 1; i >= 0; i--) begin
         lr_s.push_back(lr);
         d_s.push_back(data[i]);
      end
   endtask

   // bclk = clk/8: lrclk/sdata change while bclk is low
   task automatic drive_period(input int i);
      lrclk = lr_s[i];
      sdata = d_s[i];
      bclk  = 1'b0;
      repeat (4) tick();
      bclk = 1'b1;
      repeat (4) tick();
   endtask

   task automatic drive_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) drive_period(i);
   endtask

   // Reference: split the stream at lrclk changes; each segment's data bits
   // start one period after the change; a full segment yields its first W bits,
   // a segment cut short by another change flags a short slot.
   function automatic void model(output bit short_exp);
      int           edges[$];
      bit           prev;
      int           start, stop;
      logic [W-1:0] v;
      prev      = 1'b0;
      short_exp = 1'b0;
      exp_q.delete();
      for (int i = 0; i < lr_s.size(); i++) begin
         if (lr_s[i] != prev) edges.push_back(i);
         prev = lr_s[i];
      end
      for (int k = 0; k < edges.size(); k++) begin
         start = edges[k] + 1;
         stop  = (k + 1 < edges.size()) ? edges[k+1] : lr_s.size();
         if (stop - start >= int'(W)) begin
            v = '0;
            for (int b = 0; b < int'(W); b++)
               if (d_s[start+b]) v[int'(W)-1-b] = 1'b1;
            exp_q.push_back(word_t'({lr_s[edges[k]], v}));
         end else if (k + 1 < edges.size()) begin
            short_exp = 1'b1;
         end
      end
   endfunction

   task automatic check_outputs_zero(input string tag);
      @(negedge clk);
      check({tag, "_sample"},  32'(bus.sample_out),    32'h0);
      check({tag, "_channel"}, 32'(bus.channel_out),   32'h0);
      check({tag, "_valid"},   32'(bus.valid_out),     32'h0);
      check({tag, "_overrun"}, 32'(bus.overrun_out),   32'h0);
      check({tag, "_short"},   32'(bus.short_err_out), 32'h0);
   endtask

   initial begin
      word_t w;
      bit    short_exp;
      int    last, nslots;
      bit    lr;

      vecs[0] = '{0, CH_RIGHT, 16, 32'h0000_1357, 1'b1, 16'h1357};
      vecs[1] = '{0, CH_LEFT,  16, 32'h0000_A5C3, 1'b1, 16'hA5C3};
      vecs[2] = '{0, CH_RIGHT, 16, 32'h0000_0F0F, 1'b1, 16'h0F0F};
      vecs[3] = '{1, CH_RIGHT, 16, 32'h0000_C001, 1'b1, 16'hC001};
      vecs[4] = '{1, CH_LEFT,  10, 32'h0000_03FF, 1'b0, 16'h0000};
      vecs[5] = '{1, CH_RIGHT, 16, 32'h0000_BEEF, 1'b1, 16'hBEEF};
      vecs[6] = '{1, CH_LEFT,  24, 32'h0012_3456, 1'b1, 16'h1234};
      grp_short[0] = 1'b0;
      grp_short[1] = 1'b1;

      // Reset state
      do_reset();
      check_outputs_zero("reset");

      // Table-driven slot groups, ready held high
      for (int g = 0; g < 2; g++) begin
         do_reset();
         bus.ready_in = 1'b1;
         for (int r = 0; r < NV; r++)
            if (vecs[r].grp == g) add_slot(vecs[r].lr, vecs[r].nbits, vecs[r].data);
         drive_range(0, lr_s.size());
         repeat (8) tick();
         for (int r = 0; r < NV; r++) begin
            if (vecs[r].grp == g && vecs[r].emit) begin
               if (got_q.size() == 0) begin
                  check($sformatf("grp%0d_row%0d_missing", g, r), 32'h0, 32'h1);
               end else begin
                  w = got_q.pop_front();
                  check($sformatf("grp%0d_row%0d_word", g, r), 32'(w),
                        32'({vecs[r].lr, vecs[r].exp_sample}));
               end
            end
         end
         check($sformatf("grp%0d_extra_words", g), 32'(got_q.size()), 32'h0);
         check($sformatf("grp%0d_short", g), 32'(bus.short_err_out), 32'(grp_short[g]));
         check($sformatf("grp%0d_overrun", g), 32'(bus.overrun_out), 32'h0);
      end

      // Overrun: three words while the consumer stalls
      do_reset();
      add_slot(CH_RIGHT, 16, 32'h1111);
      add_slot(CH_LEFT,  16, 32'h2222);
      add_slot(CH_RIGHT, 16, 32'h3333);
      drive_range(0, lr_s.size());
      repeat (8) tick();
      @(negedge clk);
      check("ovr_valid",   32'(bus.valid_out),   32'h1);
      check("ovr_sample",  32'(bus.sample_out),  32'h1111);
      check("ovr_channel", 32'(bus.channel_out), 32'(CH_RIGHT));
      check("ovr_flag",    32'(bus.overrun_out), 32'h1);
      tick();
      bus.ready_in = 1'b1;
      tick();
      @(negedge clk);
      check("ovr_valid_drop", 32'(bus.valid_out), 32'h0);
      check("ovr_accepted",   32'(got_q.size()),  32'h1);
      check("ovr_sticky",     32'(bus.overrun_out), 32'h1);

      // Completion in the same cycle as the handshake
      do_reset();
      add_slot(CH_RIGHT, 16, 32'hAAAA);
      add_slot(CH_LEFT,  16, 32'h5555);
      last = lr_s.size() - 1;
      drive_range(0, last);
      lrclk = lr_s[last];
      sdata = d_s[last];
      bclk  = 1'b0;
      repeat (4) tick();
      bclk = 1'b1;
      tick();
      tick();
      bus.ready_in = 1'b1;
      @(negedge clk);
      check("same_pre_valid",  32'(bus.valid_out),  32'h1);
      check("same_pre_sample", 32'(bus.sample_out), 32'hAAAA);
      tick();
      bus.ready_in = 1'b0;
      @(negedge clk);
      check("same_post_valid",   32'(bus.valid_out),   32'h1);
      check("same_post_sample",  32'(bus.sample_out),  32'h5555);
      check("same_post_channel", 32'(bus.channel_out), 32'(CH_LEFT));
      check("same_post_overrun", 32'(bus.overrun_out), 32'h0);
      repeat (5) tick();
      check("same_accepted_cnt", 32'(got_q.size()), 32'h1);
      if (got_q.size() > 0) check("same_accepted_word", 32'(got_q[0]), 32'({CH_RIGHT, 16'hAAAA}));

      // Reset for one cycle in the middle of a slot
      do_reset();
      add_slot(CH_RIGHT, 16, 32'h1234);
      add_slot(CH_LEFT,  16, 32'hABCD);
      drive_range(0, 17 + 8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_outputs_zero("midrst");
      got_q.delete();
      lr_s.delete();
      d_s.delete();
      bus.ready_in = 1'b1;
      add_slot(CH_RIGHT, 16, 32'h7FFF);
      drive_range(0, lr_s.size());
      repeat (8) tick();
      check("midrst_cnt", 32'(got_q.size()), 32'h1);
      if (got_q.size() > 0) check("midrst_word", 32'(got_q[0]), 32'({CH_RIGHT, 16'h7FFF}));
      check("midrst_short", 32'(bus.short_err_out), 32'h0);

      // Randomized stream with a randomly stalling consumer
      do_reset();
      nslots = 16;
      lr = 1'b1;
      for (int s = 0; s < nslots; s++) begin
         if ($urandom_range(0, 3) == 0 && s > 0) lr = ~lr;
         if ($urandom_range(0, 4) == 0)
            add_slot(lr, int'($urandom_range(3, W - 1)), $urandom);
         else
            add_slot(lr, int'($urandom_range(W, 24)), $urandom);
         lr = ~lr;
      end
      model(short_exp);
      rand_ready = 1'b1;
      drive_range(0, lr_s.size());
      repeat (8) tick();
      rand_ready   = 1'b0;
      bus.ready_in = 1'b1;
      repeat (4) tick();
      check("rand_cnt", 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         if (k < got_q.size()) check($sformatf("rand_word%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
      check("rand_short",   32'(bus.short_err_out), 32'(short_exp));
      check("rand_overrun", 32'(bus.overrun_out),   32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
Serial audio receiver that consumes the bit clock produced by the team's clock divider and deserialises I2S data from the audio ADC. It synchronises bclk, lrclk and sdata into the system clock domain and detects bclk rising edges. It outputs one parallel PCM word per channel to the spectrum/visualiser front end over a valid/ready handshake. It flags overrun and short frames.

Parameters:
SAMPLE_WIDTH, 16, bits per output sample, MSB-first; extra serial bits in a slot are ignored.
SYNC_STAGES, 2, flop stages in each input synchroniser, minimum 2.

Ports:
clk_in  input  1  system clock; sole clock of the block.
rst  input  1  synchronous, active-high reset.
bclk_in  input  1  I2S bit clock, asynchronous to clk_in.
lrclk_in  input  1  I2S word select: 0 = left, 1 = right.
sdata_in  input  1  I2S serial data.
sample_out  output  SAMPLE_WIDTH  received sample, two's complement.
channel_out  output  1  channel of sample_out: 0 = left, 1 = right.
valid_out  output  1  sample_out and channel_out hold a word.
ready_in  input  1  consumer accepts the word in any cycle where valid_out & ready_in.
overrun_out  output  1  sticky; a completed word was dropped because the output was full.
short_err_out  output  1  sticky; an lrclk edge arrived before SAMPLE_WIDTH bits were captured.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst is synchronous and active-high. All state is updated on posedge clk_in.
- Reset values: sample_out=0, channel_out=0, valid_out=0, overrun_out=0, short_err_out=0. Synchronisers, shift register, bit count and lr_prev clear to 0. State goes to IDLE.
- The sticky flags clear only on rst.
- Synchronisation: each of bclk_in, lrclk_in and sdata_in passes through SYNC_STAGES flops.
- bclk_rise: one-cycle strobe, synchronised bclk AND NOT its previous registered value.
- Rate requirement: bclk high and low times are each at least 2 clk_in periods (clk_in at least 4x bclk). Behaviour below that rate is undefined.
- On each bclk_rise, the block samples synchronised lrclk (lr) and sdata (d). lr_edge = lr != lr_prev. lr_prev <= lr.
- State machine, evaluated only on bclk_rise:
  - IDLE: wait for lr_edge, then latch ch <= lr, count <= 0, go to SHIFT. Data is ignored until then.
  - SHIFT, lr_edge: partial word discarded, short_err_out <= 1, ch <= lr, count <= 0, stay in SHIFT.
  - SHIFT, no lr_edge: shift d in at the LSB, count++. When count reaches SAMPLE_WIDTH-1, complete word W = {shift[SAMPLE_WIDTH-2:0], d} and go to WAIT.
  - WAIT, lr_edge: ch <= lr, count <= 0, go to SHIFT. Other bits are ignored.
- I2S one-bit delay: the bit sampled on the same bclk_rise as lr_edge is the previous word's LSB and is discarded. The MSB is taken on the next bclk_rise.
- Output register:
  - On word completion, if valid_out=0 or (valid_out & ready_in) in the same cycle, load sample_out <= W and channel_out <= ch, and set valid_out <= 1.
  - Otherwise drop W, keep the held word unchanged, and set overrun_out <= 1.
  - A handshake with no completion clears valid_out.
  - A completion and a handshake in the same cycle load the new word with valid_out staying 1 and no overrun.
  - sample_out and channel_out are stable while valid_out=1 and not accepted.
- Latency: valid_out rises SYNC_STAGES+1 clk_in cycles after the bclk_in rising edge that carries the sample LSB, when the output is free.
- Reset mid-word: the partial word is lost and the block restarts in IDLE. The first full slot after the next lrclk edge is received correctly.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_WIDTH_DEFAULT = 16;
  - CH_LEFT = 1'b0 and CH_RIGHT = 1'b1;
  - typedef enum i2s_rx_state_t {IDLE, SHIFT, WAIT}.
- Sub-module sync_edge_det (SYNC_STAGES): synchroniser plus a rising-edge strobe. It is instanced for bclk. It is also instanced for lrclk and sdata with the edge output unused.

Test Plan:
- Reset, bclk = clk_in/8, ready_in=1; frames left=16'hA5C3 then right=16'h0F0F, 16 bits per slot -> two valid_out pulses: (16'hA5C3, ch 0) then (16'h0F0F, ch 1); no flags set.
- ready_in=0 across three completed words 16'h1111, 16'h2222, 16'h3333 -> sample_out holds 16'h1111 with valid_out=1 and overrun_out=1. On ready_in=1 it is accepted and valid_out drops.
- Word completion in the same cycle as the handshake -> valid_out stays 1, sample_out updates next cycle, overrun_out stays 0.
- lrclk toggles after 10 bits of a slot -> short_err_out=1 and no valid_out for that slot. The following full slot 16'hBEEF is output correctly.
- 24-bit slots, data 24'h123456, SAMPLE_WIDTH=16 -> sample_out=16'h1234 and the remaining 8 bits are ignored.
- Assert rst for 1 cycle mid-slot -> all outputs are 0 the next cycle. The partial slot produces no output, and the first slot after the next lrclk edge (16'h7FFF) is correct.
